// File: rtl/regex_stim_pkg.sv
// Shared types and constants for the regex matcher stimulus generator.
package regex_stim_pkg;

  typedef enum logic [2:0] {IDLE, PREFIX, MARK, TAIL, DONE} state_e;

  localparam int          TAIL_LEN_DEF  = 20;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // Taps are given in polynomial order (bit 15 = x^16); the register shifts right,
  // so the mask is applied to the bit-reversed state to pick q[0], q[2], q[3], q[5].
  function automatic logic lfsr_fb(input logic [15:0] q);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = q[15-i];
    return ^(r & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load (zero seed substituted) and advance enable.
module stim_lfsr16
  import regex_stim_pkg::*;
#(
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
    else if (adv)
      q_d = {lfsr_fb(q_q), q_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED_RST;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regex_stim_gen.sv
// Character-stream generator for the (0|1)*1(0|1){TAIL_LEN} matcher, with reference verdict.
// Optional feature: define REGEX_STIM_NEGATIVE_EN to add the `negative` input (mark emits 0).
module regex_stim_gen
  import regex_stim_pkg::*;
#(
  parameter int          TAIL_LEN = TAIL_LEN_DEF,
  parameter int          PFX_W    = 4,
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PFX_W-1:0] prefix_len,
`ifdef REGEX_STIM_NEGATIVE_EN
  input  logic             negative,
`endif
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic             ch,
  output logic             ch_valid,
  input  logic             ch_ready,
  output logic             tok,
  output logic             exp_match,
  output logic             exp_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = PFX_W + 6;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PFX_W-1:0]   pfx_q, pfx_d;
  logic               first_q, first_d;
  logic [TAIL_LEN:0]  win_q, win_d;
  logic               em_q, em_d;
  logic               ev_q, ev_d;
  logic               neg_q, neg_d;
  logic [15:0]        lfsr_q;
  logic               unused_lfsr;
  logic               mark_bit;
  logic               xfer;
  logic               lfsr_adv;
  logic [CNT_W-1:0]   cnt_last;

`ifdef REGEX_STIM_NEGATIVE_EN
  assign mark_bit = ~neg_q;
`else
  assign mark_bit = 1'b1;
`endif

  assign unused_lfsr = ^lfsr_q[15:1];
  assign ch_valid    = (state_q == PREFIX) || (state_q == MARK) || (state_q == TAIL);
  assign ch          = ch_valid & ((state_q == MARK) ? mark_bit : lfsr_q[0]);
  assign tok         = ch_valid & first_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign exp_match   = em_q;
  assign exp_valid   = ev_q;
  assign xfer        = ch_valid & ch_ready;
  assign lfsr_adv    = xfer & ((state_q == PREFIX) || (state_q == TAIL));
  // cnt_q indexes the character being offered; the last one sits at prefix + TAIL_LEN.
  assign cnt_last    = CNT_W'(pfx_q) + CNT_W'(TAIL_LEN);

  stim_lfsr16 #(.SEED_RST(SEED_RST)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (seed_load && (state_q == IDLE)),
    .seed (seed),
    .adv  (lfsr_adv),
    .q    (lfsr_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pfx_d   = pfx_q;
    first_d = first_q;
    win_d   = win_q;
    em_d    = em_q;
    ev_d    = ev_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pfx_d   = prefix_len;
          cnt_d   = '0;
          first_d = 1'b1;
          win_d   = '0;
          em_d    = 1'b0;
          ev_d    = 1'b0;
`ifdef REGEX_STIM_NEGATIVE_EN
          neg_d   = negative;
`else
          neg_d   = 1'b0;
`endif
          state_d = (prefix_len != '0) ? PREFIX : MARK;
        end
      end
      PREFIX:  if (xfer && (cnt_q == CNT_W'(pfx_q) - CNT_W'(1))) state_d = MARK;
      MARK:    if (xfer) state_d = TAIL;
      TAIL:    if (xfer && (cnt_q == cnt_last)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Transfers only happen in PREFIX/MARK/TAIL, so they never collide with the start clear.
    if (xfer) begin
      cnt_d   = cnt_q + CNT_W'(1);
      first_d = 1'b0;
      win_d   = {win_q[TAIL_LEN-1:0], ch};
      em_d    = win_d[TAIL_LEN];
      if (cnt_q >= CNT_W'(TAIL_LEN)) ev_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pfx_q   <= '0;
      first_q <= 1'b0;
      win_q   <= '0;
      em_q    <= 1'b0;
      ev_q    <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pfx_q   <= pfx_d;
      first_q <= first_d;
      win_q   <= win_d;
      em_q    <= em_d;
      ev_q    <= ev_d;
      neg_q   <= neg_d;
    end
  end

endmodule
